// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state, mode types and mode constants for the SPI master
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      TRANSFER,
      HOLD
   } state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK half-period divider, tick on the last count of each period
module spi_clk_div #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - full-duplex SPI master with runtime mode, bit order and slave select
module spi_master_multi
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_SS  = 4,
   parameter int CLK_DIV = 50
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         start,
   input  logic                                         abort,
   input  logic [DATA_W-1:0]                            tx_data,
   input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
   input  logic [1:0]                                   mode,
   input  logic                                         lsb_first,
   input  logic                                         miso,
   output logic                                         tx_ready,
   output logic                                         done,
   output logic [DATA_W-1:0]                            rx_data,
   output logic                                         sclk,
   output logic                                         mosi,
   output logic [NUM_SS-1:0]                            ss_n
);

   localparam int EW = $clog2(2 * DATA_W) + 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   spi_mode_t         mode_q, mode_d;
   logic              lsb_q, lsb_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;
   logic              done_q, done_d;
   logic              tick;
   logic              div_clear;
   int                e;

   // Bit k of the word in wire order (k = 0 is the first bit on the line).
   function automatic logic order_bit(input logic [DATA_W-1:0] w, input logic lsb, input int k);
      logic [DATA_W-1:0] s;
      s = lsb ? (w >> k) : (w << k);
      return lsb ? s[0] : s[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] put_bit(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input int k, input logic b);
      logic [DATA_W-1:0] m;
      m = lsb ? ({{(DATA_W-1){1'b0}}, 1'b1} << k) : ({1'b1, {(DATA_W-1){1'b0}}} >> k);
      return b ? (w | m) : (w & ~m);
   endfunction

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk   (clk),
      .reset (reset),
      .clear (div_clear),
      .tick  (tick)
   );

   assign div_clear = (state_q == IDLE) || (state_d != state_q);

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      mode_d    = mode_q;
      lsb_d     = lsb_q;
      edge_d    = edge_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_n_d    = ss_n_q;
      done_d    = 1'b0;
      e         = int'(edge_q) + 1;

      case (state_q)
         IDLE: begin
            sclk_d = mode[1];
            mosi_d = 1'b0;
            ss_n_d = '1;
            if (start && !abort) begin
               state_d = SETUP;
               tx_d    = tx_data;
               mode_d  = spi_mode_t'(mode);
               lsb_d   = lsb_first;
               edge_d  = '0;
               rx_sh_d = '0;
               mosi_d  = mode[0] ? 1'b0 : order_bit(tx_data, lsb_first, 0);
               for (int i = 0; i < NUM_SS; i++) begin
                  if (int'(ss_sel) == i) begin
                     ss_n_d[i] = 1'b0;
                  end
               end
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = TRANSFER;
            end
         end
         TRANSFER: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               edge_d = edge_q + 1'b1;
               // e is the number of the sclk edge this tick produces; odd = leading.
               if (e[0]) begin
                  if (mode_q.cpha) begin
                     mosi_d = order_bit(tx_q, lsb_q, (e - 1) / 2);
                  end else begin
                     rx_sh_d = put_bit(rx_sh_q, lsb_q, (e - 1) / 2, miso);
                  end
               end else begin
                  if (mode_q.cpha) begin
                     rx_sh_d = put_bit(rx_sh_q, lsb_q, e / 2 - 1, miso);
                  end else if (e < 2 * DATA_W) begin
                     mosi_d = order_bit(tx_q, lsb_q, e / 2);
                  end
               end
               if (e == 2 * DATA_W) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            sclk_d = mode_q.cpol;
            if (tick) begin
               state_d   = IDLE;
               ss_n_d    = '1;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
               mosi_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         ss_n_d    = '1;
         sclk_d    = mode_q.cpol;
         mosi_d    = 1'b0;
         done_d    = 1'b0;
         rx_data_d = rx_data_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tx_q      <= '0;
         mode_q    <= MODE0;
         lsb_q     <= 1'b0;
         edge_q    <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_n_q    <= '1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         mode_q    <= mode_d;
         lsb_q     <= lsb_d;
         edge_q    <= edge_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_n_q    <= ss_n_d;
         done_q    <= done_d;
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign done     = done_q;
   assign rx_data  = rx_data_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - directed table, random transfers and corner sequences for spi_master_multi
module tb_spi_master_multi;

   localparam int W   = 8;
   localparam int NSS = 3;
   localparam int DIV = 4;
   localparam int LAT = 1 + (2 * W + 2) * DIV;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [W-1:0]   tx_data = '0;
   logic [1:0]     ss_sel = '0;
   logic [1:0]     mode = '0;
   logic           lsb_first = 1'b0;
   logic           loopback = 1'b0;
   logic           miso;
   logic           tx_ready, done, sclk, mosi;
   logic [W-1:0]   rx_data;
   logic [NSS-1:0] ss_n;

   logic           cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
   logic [W-1:0]   cfg_resp = '0;

   logic           slave_miso = 1'b0, sclk_prev = 1'b0, act_prev = 1'b0;
   logic           act, smp;
   int             s_in = 0, s_out = 0, edges = 0;
   logic [W-1:0]   s_seen = '0;

   int n_tests = 0, n_fail = 0;

   spi_master_multi #(.DATA_W(W), .NUM_SS(NSS), .CLK_DIV(DIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .tx_data   (tx_data),
      .ss_sel    (ss_sel),
      .mode      (mode),
      .lsb_first (lsb_first),
      .miso      (miso),
      .tx_ready  (tx_ready),
      .done      (done),
      .rx_data   (rx_data),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss_n      (ss_n)
   );

   always #5 clk = ~clk;

   assign miso = loopback ? mosi : slave_miso;

   function automatic logic [2:0] wire_pos(input logic lsb, input int k);
      return lsb ? k[2:0] : 3'(W - 1 - k);
   endfunction

   function automatic logic bit_at(input logic [W-1:0] w, input logic lsb, input int k);
      logic [2:0] p;
      p = wire_pos(lsb, k);
      return w[p];
   endfunction

   function automatic logic [NSS-1:0] sel_mask(input logic [1:0] s);
      logic [NSS-1:0] r;
      r = {NSS{1'b1}};
      if (int'(s) < NSS) r[s] = 1'b0;
      return r;
   endfunction

   function automatic logic [W-1:0] ref_rx(input logic [W-1:0] tx, input logic [W-1:0] resp, input logic lp);
      return lp ? tx : resp;
   endfunction

   // Behavioural slave: acts on sclk transitions seen while any select is low.
   assign act = (ss_n != {NSS{1'b1}});
   assign smp = ((sclk != cfg_cpol) == !cfg_cpha);

   always @(negedge clk) begin
      sclk_prev <= sclk;
      act_prev  <= act;
      if (!act) begin
         s_in       <= 0;
         s_out      <= cfg_cpha ? 0 : 1;
         slave_miso <= cfg_cpha ? 1'b0 : bit_at(cfg_resp, cfg_lsb, 0);
      end else begin
         if (!act_prev) begin
            edges  <= 0;
            s_seen <= '0;
         end
         if (sclk != sclk_prev) begin
            edges <= edges + 1;
            if (smp) begin
               if (s_in < W) begin
                  s_seen[wire_pos(cfg_lsb, s_in)] <= mosi;
                  s_in <= s_in + 1;
               end
            end else if (s_out < W) begin
               slave_miso <= bit_at(cfg_resp, cfg_lsb, s_out);
               s_out      <= s_out + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Leaves the bench at #1 after the accepting edge (cycle N+1).
   task automatic launch(input logic [1:0] m, input logic [1:0] sel, input logic lsb,
                         input logic [W-1:0] tx, input logic [W-1:0] resp, input logic lp,
                         input bit pre_wait);
      mode = m; ss_sel = sel; lsb_first = lsb; tx_data = tx; loopback = lp;
      cfg_cpol = m[1]; cfg_cpha = m[0]; cfg_lsb = lsb; cfg_resp = resp;
      if (pre_wait) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic watch(input int limit, input logic [NSS-1:0] exp_ss, input int poke_c,
                        output int done_c, output int n_done, output int ss_bad);
      logic [NSS-1:0] want;
      done_c = 0; n_done = 0; ss_bad = 0;
      for (int c = 1; c <= limit; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         start = 1'b0;
         want = (c < LAT) ? exp_ss : {NSS{1'b1}};
         if (ss_n !== want) ss_bad++;
         if (done === 1'b1) begin
            n_done++;
            if (done_c == 0) done_c = c;
         end
         if (c == poke_c) begin
            start   = 1'b1;
            tx_data = ~tx_data;
         end
         if (done === 1'b1 && poke_c == 0) break;
      end
   endtask

   typedef struct {
      logic [1:0] m;
      logic [1:0] sel;
      logic       lsb;
      logic [W-1:0] tx;
      logic [W-1:0] resp;
      logic       lp;
      logic [W-1:0] exp_rx;
      logic [W-1:0] exp_seen;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int dc, nd, sb;
      logic [W-1:0] prev_rx, rtx, rresp;
      logic [1:0]   rm, rsel;
      logic         rlsb, rlp;

      vecs[0] = '{2'b00, 2'd0, 1'b0, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5};
      vecs[1] = '{2'b11, 2'd2, 1'b0, 8'hC3, 8'h3C, 1'b0, 8'h3C, 8'hC3};
      vecs[2] = '{2'b01, 2'd1, 1'b1, 8'h01, 8'hD2, 1'b0, 8'hD2, 8'h01};
      vecs[3] = '{2'b10, 2'd0, 1'b1, 8'hF0, 8'h0F, 1'b0, 8'h0F, 8'hF0};
      vecs[4] = '{2'b00, 2'd3, 1'b0, 8'h55, 8'hAA, 1'b0, 8'h00, 8'h00};

      repeat (3) @(posedge clk);
      #1;
      check("reset_tx_ready", tx_ready, 1);
      check("reset_done", done, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_sclk", sclk, 0);
      check("reset_mosi", mosi, 0);
      check("reset_ss_n", ss_n, 3'b111);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         launch(vecs[i].m, vecs[i].sel, vecs[i].lsb, vecs[i].tx, vecs[i].resp, vecs[i].lp, 1);
         watch(LAT + 10, sel_mask(vecs[i].sel), 0, dc, nd, sb);
         check("vec_latency", dc, LAT);
         check("vec_ss_n", sb, 0);
         check("vec_idle_sclk", sclk, vecs[i].m[1]);
         if (int'(vecs[i].sel) < NSS) begin
            check("vec_rx_data", rx_data, vecs[i].exp_rx);
            check("vec_slave_seen", s_seen, vecs[i].exp_seen);
            check("vec_sclk_edges", edges, 2 * W);
         end
         @(posedge clk); #1;
      end

      for (int i = 0; i < 24; i++) begin
         rm    = 2'($urandom_range(0, 3));
         rsel  = 2'($urandom_range(0, NSS - 1));
         rlsb  = 1'($urandom_range(0, 1));
         rtx   = 8'($urandom);
         rresp = 8'($urandom);
         rlp   = (i % 4 == 3);
         launch(rm, rsel, rlsb, rtx, rresp, rlp, 1);
         watch(LAT + 10, sel_mask(rsel), 0, dc, nd, sb);
         check("rand_latency", dc, LAT);
         check("rand_ss_n", sb, 0);
         check("rand_rx_data", rx_data, ref_rx(rtx, rresp, rlp));
         check("rand_slave_seen", s_seen, rtx);
      end

      launch(2'b00, 2'd1, 1'b0, 8'h3A, 8'h96, 1'b0, 1);
      watch(LAT + 20, sel_mask(2'd1), 10, dc, nd, sb);
      check("busy_done_count", nd, 1);
      check("busy_latency", dc, LAT);
      check("busy_ss_n", sb, 0);
      check("busy_rx_data", rx_data, 8'h96);
      check("busy_slave_seen", s_seen, 8'h3A);

      launch(2'b11, 2'd0, 1'b0, 8'h81, 8'h7E, 1'b0, 1);
      watch(LAT + 10, sel_mask(2'd0), 0, dc, nd, sb);
      check("b2b_first_latency", dc, LAT);
      check("b2b_first_rx", rx_data, 8'h7E);
      check("b2b_gap_ss_n", ss_n, 3'b111);
      launch(2'b11, 2'd2, 1'b1, 8'h4D, 8'hB2, 1'b0, 0);
      check("b2b_second_ss_n", ss_n, sel_mask(2'd2));
      watch(LAT + 10, sel_mask(2'd2), 0, dc, nd, sb);
      check("b2b_second_latency", dc, LAT);
      check("b2b_second_rx", rx_data, 8'hB2);
      check("b2b_second_seen", s_seen, 8'h4D);

      prev_rx = rx_data;
      launch(2'b10, 2'd1, 1'b0, 8'h5C, 8'h33, 1'b0, 1);
      watch(20, sel_mask(2'd1), 0, dc, nd, sb);
      check("abort_pre_ss_n", sb, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_ss_n", ss_n, 3'b111);
      check("abort_tx_ready", tx_ready, 1);
      check("abort_sclk", sclk, 1);
      nd = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (done === 1'b1) nd++;
      end
      check("abort_no_done", nd, 0);
      check("abort_rx_kept", rx_data, prev_rx);

      start = 1'b1; abort = 1'b1; ss_sel = 2'd0;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_start_ready", tx_ready, 1);
      check("abort_start_ss_n", ss_n, 3'b111);

      launch(2'b01, 2'd0, 1'b1, 8'hE7, 8'h18, 1'b0, 1);
      watch(30, sel_mask(2'd0), 0, dc, nd, sb);
      check("rst_pre_done", nd, 0);
      #2 reset = 1'b1;
      #1;
      check("rst_ss_n", ss_n, 3'b111);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_done", done, 0);
      check("rst_rx_data", rx_data, 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      launch(2'b01, 2'd0, 1'b1, 8'hE7, 8'h18, 1'b0, 1);
      watch(LAT + 10, sel_mask(2'd0), 0, dc, nd, sb);
      check("rst_after_latency", dc, LAT);
      check("rst_after_rx", rx_data, 8'h18);
      check("rst_after_seen", s_seen, 8'hE7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised full-duplex SPI master; next generation of the single-slave, fixed-mode, 8-bit transmit-only master used by the counter/FND link.
- Adds generic data width, runtime CPOL/CPHA mode, MSB/LSB-first order, MISO receive, multiple slave selects and abort.
- Sits between a control FSM (counter or command sequencer) and off-chip or on-board SPI slaves.

Parameters:
- DATA_W, 8: bits per transfer (>=2).
- NUM_SS, 4: number of active-low slave-select lines (>=1).
- CLK_DIV, 50: clk cycles per SCLK half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; accepted only when tx_ready=1.
- abort  in  1  synchronous cancel of the current transfer.
- tx_data  in  DATA_W  word to send; latched on accept.
- ss_sel  in  max(1,$clog2(NUM_SS))  slave index; latched on accept.
- mode  in  2  {CPOL,CPHA}; latched on accept.
- lsb_first  in  1  1 = LSB shifted first; latched on accept.
- miso  in  1  serial input from slave.
- tx_ready  out  1  idle, start accepted.
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  DATA_W  received word; valid from done until next done.
- sclk  out  1  serial clock.
- mosi  out  1  serial output.
- ss_n  out  NUM_SS  slave selects, active low.

Behaviour:
- Reset: state IDLE, tx_ready=1, done=0, rx_data=0, sclk=0, mosi=0, ss_n all 1, divider 0.
- States: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE. Divider counts 0..CLK_DIV-1; a tick fires at CLK_DIV-1 and the counter restarts on state entry.
- IDLE: tx_ready=1; sclk registered to mode[1] every cycle; mosi=0.
- Accept: start=1 and tx_ready=1 at edge N latches tx_data, ss_sel, mode and lsb_first. From N+1: SETUP, tx_ready=0, ss_n[ss_sel]=0.
- ss_sel>=NUM_SS: the transfer still runs; all ss_n stay 1.
- SETUP: lasts CLK_DIV cycles. If CPHA=0, mosi carries bit 0 of the selected order from entry.
- TRANSFER: 2*DATA_W ticks, each toggling sclk. Odd edges are leading, even edges are trailing.
  - CPHA=0: sample miso on leading edge; advance mosi on trailing edges 2..2W-2.
  - CPHA=1: mosi takes bit k on leading edge 2k+1; sample miso on trailing edge.
  - Sampled bits fill rx in the same order as sent, so lsb_first applies to both directions.
- HOLD: CLK_DIV cycles; sclk at CPOL, ss_n still asserted.
- On HOLD tick: in the same cycle ss_n all go 1, done=1 for one cycle, rx_data updates, tx_ready=1, state returns to IDLE, mosi=0.
- Latency: done asserted at edge N+1+(2*DATA_W+2)*CLK_DIV.
- Back-to-back: start in the done cycle is accepted; ss_n is high for exactly that one cycle.
- start while busy: ignored, no queuing.
- abort (any non-IDLE state): next cycle IDLE, ss_n all 1, sclk=CPOL, no done, rx_data unchanged. abort in IDLE has no effect. abort together with an accepting start: the abort wins and start is dropped.
- Reset mid-transfer: immediate return to reset values; no done.

Decomposition:
- Package spi_pkg:
  - state_e enum {IDLE,SETUP,TRANSFER,HOLD};
  - spi_mode_t packed struct {cpol,cpha};
  - MODE0..MODE3 constants.
- Sub-module spi_clk_div (param CLK_DIV): inputs clk, reset, clear; output tick.
- Shift, sample and select logic stay in the top module.

Test Plan:
- DATA_W=8, CLK_DIV=4, mode 0, tx 8'hA5, miso tied to mosi: rx_data=8'hA5; done at N+73; 16 sclk edges; ss_n[0] low N+1..N+72.
- Mode 3, ss_sel=2, slave model returns 8'h3C, tx 8'hC3: slave sees 8'hC3, rx_data=8'h3C; sclk idles 1; only ss_n[2] asserted.
- lsb_first=1, mode 1, tx 8'h01: mosi=1 after the first leading edge, then 0; slave sees LSB-first word 8'h01.
- start pulsed at N+10 during a transfer: ignored; exactly one done. start in the done cycle: second transfer begins; ss_n high one cycle.
- abort at N+20: ss_n all 1 and state IDLE at N+21; no done; rx_data keeps previous value.
- reset asserted at N+30: asynchronous return to reset values; next start completes normally.
